// File: rtl/sync_cnt_pkg.sv
// Shared encodings for the parametrised modulus counter.
// Holds the mode codes and the count-direction constants.
package sync_cnt_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_cell.sv
// Single count bit: T flip-flop with a synchronous direct-load path.
// Reset beats load, and load beats toggle.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/sync_mod_counter.sv
// Modulus counter built from a toggle chain of T cells; terminal-count
// handling (wrap, saturate, bounce) and loads go through the cells' load path.
module sync_mod_counter
    import sync_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             cur_dir
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             bdir_reg;
    logic             bdir_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             eff_dir;
    logic             at_term;
    logic             out_of_range;
    logic             ovr;
    logic [WIDTH-1:0] ovr_val;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] zeros;
    logic [WIDTH-1:0] t;

    assign eff_dir      = (mode == MODE_BOUNCE) ? bdir_reg : dir;
    assign at_term      = (q == ((eff_dir == DIR_DOWN) ? '0 : MAX));
    assign out_of_range = (q > MAX);

    assign tc      = at_term;
    assign cur_dir = eff_dir;
    assign wrap    = wrap_reg;

    // Away from the terminal value the plain toggle chain gives q +/- 1;
    // every edge that leaves that path is forced through the load path.
    always_comb begin
        ovr       = 1'b0;
        ovr_val   = q;
        bdir_next = bdir_reg;
        wrap_next = 1'b0;
        if (load) begin
            ovr       = 1'b1;
            ovr_val   = (load_val > MAX) ? MAX : load_val;
            bdir_next = dir;
        end else if (en) begin
            if (out_of_range) begin
                ovr     = 1'b1;
                ovr_val = '0;
            end else if (at_term) begin
                ovr = 1'b1;
                case (mode)
                    MODE_SAT: begin
                        ovr_val = q;
                    end
                    MODE_BOUNCE: begin
                        ovr_val   = (eff_dir == DIR_DOWN) ? WIDTH'(1) : (MAX - WIDTH'(1));
                        bdir_next = ~bdir_reg;
                        wrap_next = 1'b1;
                    end
                    default: begin
                        ovr_val   = (eff_dir == DIR_DOWN) ? MAX : '0;
                        wrap_next = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bdir_reg <= DIR_UP;
            wrap_reg <= 1'b0;
        end else begin
            bdir_reg <= bdir_next;
            wrap_reg <= wrap_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign ones[gi]  = 1'b1;
                assign zeros[gi] = 1'b1;
            end else begin : g_upper
                assign ones[gi]  = ones[gi-1] & q[gi-1];
                assign zeros[gi] = zeros[gi-1] & ~q[gi-1];
            end

            assign t[gi] = en & ((eff_dir == DIR_DOWN) ? zeros[gi] : ones[gi]);

            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (t[gi]),
                .ld  (ovr),
                .d   (ovr_val[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_mod_counter.sv
// Self-checking bench: directed vector table, randomized run against an
// arithmetic reference model, and corner sequences for small moduli.
module tb_sync_mod_counter;
    import sync_cnt_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = '0;
    logic       dir = 1'b0;
    logic [1:0] mode = MODE_WRAP;

    logic [3:0] qa;
    logic       tca, wa, cda;
    logic [2:0] qb;
    logic       tcb, wb, cdb;
    logic [2:0] qc;
    logic       tcc, wc, cdc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv), .dir(dir),
        .mode(mode), .q(qa), .tc(tca), .wrap(wa), .cur_dir(cda)
    );
    sync_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv[2:0]), .dir(dir),
        .mode(mode), .q(qb), .tc(tcb), .wrap(wb), .cur_dir(cdb)
    );
    sync_mod_counter #(.WIDTH(3), .MODULUS(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv[2:0]), .dir(dir),
        .mode(mode), .q(qc), .tc(tcc), .wrap(wc), .cur_dir(cdc)
    );

    typedef struct {
        logic       rst, en, load;
        logic [3:0] lv;
        logic       dir;
        logic [1:0] mode;
        int         q;
        logic       tc, w, cd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, e, l, input int v, input logic d, input logic [1:0] m,
                       input int eq, input logic etc, ew, ecd);
        vec_t x;
        x.rst = r; x.en = e; x.load = l; x.lv = 4'(v); x.dir = d; x.mode = m;
        x.q = eq; x.tc = etc; x.w = ew; x.cd = ecd;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, e, l, input logic [3:0] v, input logic d, input logic [1:0] m);
        rst = r; en = e; load = l; lv = v; dir = d; mode = m;
    endtask

    // Reference model: count range arithmetic straight from the mode rules.
    task automatic model(input int md, input logic r, e, l, input int v, input logic d,
                         input logic [1:0] m, inout int mq, inout int bd, output int w);
        int mx;
        int n;
        mx = md - 1;
        w  = 0;
        if (r) begin
            mq = 0; bd = 0;
        end else if (l) begin
            mq = (v > mx) ? mx : v;
            bd = d;
        end else if (e) begin
            if (m == MODE_SAT) begin
                if (d) mq = (mq > 0) ? mq - 1 : 0;
                else   mq = (mq < mx) ? mq + 1 : mx;
            end else if (m == MODE_BOUNCE) begin
                if (bd == 0) begin
                    if (mq == mx) begin mq = mx - 1; bd = 1; w = 1; end
                    else mq = mq + 1;
                end else begin
                    if (mq == 0) begin mq = 1; bd = 0; w = 1; end
                    else mq = mq - 1;
                end
            end else begin
                n = d ? mq - 1 : mq + 1;
                if (n < 0 || n > mx) w = 1;
                mq = (n + md) % md;
            end
        end
    endtask

    function automatic logic exp_tc(int mq, int bd, int md, logic d, logic [1:0] m);
        int ed;
        ed = (m == MODE_BOUNCE) ? bd : int'(d);
        return (mq == ((ed != 0) ? 0 : md - 1));
    endfunction

    initial begin
        int mods[3];
        int mq[3];
        int mbd[3];
        int mw[3];
        int aq[3];
        logic atc[3], aw[3], acd[3];
        logic r, e, l, d;
        logic [1:0] m;
        logic [3:0] v;

        // Reset and WRAP up
        add(1,0,0,0,0,MODE_WRAP, 0,0,0,0);
        add(1,0,0,0,0,MODE_WRAP, 0,0,0,0);
        for (int i = 1; i <= 9; i++) add(0,1,0,0,0,MODE_WRAP, i, (i == 9), 0, 0);
        add(0,1,0,0,0,MODE_WRAP, 0,0,1,0);
        add(0,1,0,0,0,MODE_WRAP, 1,0,0,0);
        // WRAP down
        add(0,0,1,2,1,MODE_WRAP, 2,0,0,1);
        add(0,1,0,0,1,MODE_WRAP, 1,0,0,1);
        add(0,1,0,0,1,MODE_WRAP, 0,1,0,1);
        add(0,1,0,0,1,MODE_WRAP, 9,0,1,1);
        add(0,1,0,0,1,MODE_WRAP, 8,0,0,1);
        // SAT up then down
        add(0,0,1,7,0,MODE_SAT, 7,0,0,0);
        add(0,1,0,0,0,MODE_SAT, 8,0,0,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0,MODE_SAT, 9,1,0,0);
        for (int i = 8; i >= 0; i--) add(0,1,0,0,1,MODE_SAT, i, (i == 0), 0, 1);
        add(0,1,0,0,1,MODE_SAT, 0,1,0,1);
        add(0,1,0,0,1,MODE_SAT, 0,1,0,1);
        // BOUNCE reversal at MAX; dir ignored after load
        add(0,0,1,8,0,MODE_BOUNCE, 8,0,0,0);
        add(0,1,0,0,1,MODE_BOUNCE, 9,1,0,0);
        add(0,1,0,0,1,MODE_BOUNCE, 8,0,1,1);
        add(0,1,0,0,1,MODE_BOUNCE, 7,0,0,1);
        // Load clamp, wrap from clamped value
        add(0,0,1,15,0,MODE_WRAP, 9,1,0,0);
        add(0,1,0,0,0,MODE_WRAP, 0,0,1,0);
        add(0,1,0,0,0,MODE_WRAP, 1,0,0,0);
        // Load beats en, reset beats everything
        add(0,1,1,5,1,MODE_BOUNCE, 5,0,0,1);
        add(0,1,0,0,0,MODE_BOUNCE, 4,0,0,1);
        add(1,1,1,5,1,MODE_BOUNCE, 0,0,0,0);
        // Hold with en=0
        for (int i = 1; i <= 3; i++) add(0,1,0,0,0,MODE_WRAP, i,0,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0,MODE_WRAP, 3,0,0,0);
        // wrap clears when idle; reserved mode acts as WRAP
        add(0,0,1,9,0,MODE_WRAP, 9,1,0,0);
        add(0,1,0,0,0,MODE_WRAP, 0,0,1,0);
        add(0,0,0,0,0,MODE_WRAP, 0,0,0,0);
        add(0,0,1,0,1,2'b11, 0,1,0,1);
        add(0,1,0,0,1,2'b11, 9,0,1,1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].lv, vecs[i].dir, vecs[i].mode);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_q", i), 32'(qa), 32'(vecs[i].q));
            chk($sformatf("vec%0d_tc", i), 32'(tca), 32'(vecs[i].tc));
            chk($sformatf("vec%0d_wrap", i), 32'(wa), 32'(vecs[i].w));
            chk($sformatf("vec%0d_cur_dir", i), 32'(cda), 32'(vecs[i].cd));
            $display("vec %0d q=%0d tc=%0b wrap=%0b cur_dir=%0b", i, qa, tca, wa, cda);
        end

        // Randomized run on all three instances against the model
        mods[0] = 10; mods[1] = 8; mods[2] = 2;
        for (int k = 0; k < 3; k++) begin mq[k] = 0; mbd[k] = 0; end
        for (int c = 0; c < 300; c++) begin
            r = (c == 0) || ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            m = 2'($urandom);
            v = 4'($urandom);
            drive(r, e, l, v, d, m);
            for (int k = 0; k < 3; k++)
                model(mods[k], r, e, l, (k == 0) ? int'(v) : int'(v[2:0]), d, m, mq[k], mbd[k], mw[k]);
            @(posedge clk); #1;
            aq[0] = int'(qa); atc[0] = tca; aw[0] = wa; acd[0] = cda;
            aq[1] = int'(qb); atc[1] = tcb; aw[1] = wb; acd[1] = cdb;
            aq[2] = int'(qc); atc[2] = tcc; aw[2] = wc; acd[2] = cdc;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rnd%0d_m%0d_q", c, mods[k]), 32'(aq[k]), 32'(mq[k]));
                chk($sformatf("rnd%0d_m%0d_tc", c, mods[k]), 32'(atc[k]),
                    32'(exp_tc(mq[k], mbd[k], mods[k], d, m)));
                chk($sformatf("rnd%0d_m%0d_wrap", c, mods[k]), 32'(aw[k]), 32'(mw[k]));
                chk($sformatf("rnd%0d_m%0d_cur_dir", c, mods[k]), 32'(acd[k]),
                    32'((m == MODE_BOUNCE) ? mbd[k] : int'(d)));
            end
            $display("rnd %0d rst=%0b en=%0b load=%0b lv=%0d dir=%0b mode=%0d qa=%0d qb=%0d qc=%0d",
                     c, r, e, l, v, d, m, qa, qb, qc);
        end

        // Full binary range: WIDTH=3, MODULUS=8 WRAP up then one step down
        drive(1, 0, 0, 0, 0, MODE_WRAP);
        @(posedge clk); #1;
        chk("m8_reset_q", 32'(qb), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 0, 0, 0, MODE_WRAP);
            @(posedge clk); #1;
            chk($sformatf("m8_up%0d_q", i), 32'(qb), 32'(i % 8));
            chk($sformatf("m8_up%0d_wrap", i), 32'(wb), 32'(i == 8));
            chk($sformatf("m8_up%0d_tc", i), 32'(tcb), 32'(i == 7));
            $display("m8 up %0d q=%0d wrap=%0b tc=%0b", i, qb, wb, tcb);
        end
        drive(0, 1, 0, 0, 1, MODE_WRAP);
        @(posedge clk); #1;
        chk("m8_down_q", 32'(qb), 32'd7);
        chk("m8_down_wrap", 32'(wb), 32'd1);
        $display("m8 down q=%0d wrap=%0b", qb, wb);

        // MODULUS=2 BOUNCE toggles with a wrap pulse on every reversal
        drive(1, 0, 0, 0, 0, MODE_BOUNCE);
        @(posedge clk); #1;
        chk("m2_reset_q", 32'(qc), 32'd0);
        chk("m2_reset_cur_dir", 32'(cdc), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 1, 0, 0, 0, MODE_BOUNCE);
            @(posedge clk); #1;
            chk($sformatf("m2_step%0d_q", i), 32'(qc), 32'(i % 2));
            chk($sformatf("m2_step%0d_wrap", i), 32'(wc), 32'(i >= 2));
            chk($sformatf("m2_step%0d_cur_dir", i), 32'(cdc), 32'((i % 2) == 0));
            chk($sformatf("m2_step%0d_tc", i), 32'(tcc), 32'd1);
            $display("m2 step %0d q=%0d wrap=%0b cur_dir=%0b tc=%0b", i, qc, wc, cdc, tcc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
